// File: rtl/button_event_gen_if.sv
// Button level inputs and command event outputs between the debounce
// stage and the watch control FSM.
interface button_event_gen_if;
    logic mode_level;
    logic add_level;
    logic sub_level;
    logic mode_short;
    logic mode_long;
    logic add_step;
    logic sub_step;
    logic repeating;

    modport master (
        output mode_level, add_level, sub_level,
        input  mode_short, mode_long, add_step, sub_step, repeating
    );

    modport slave (
        input  mode_level, add_level, sub_level,
        output mode_short, mode_long, add_step, sub_step, repeating
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns debounced mode/add/sub levels into single-cycle command events:
// short/long mode presses, add/sub steps with auto-repeat, chord lockout.
//
// state    | meaning
// M_IDLE   | mode released, waiting for a fresh press
// M_HELD   | mode held, timing toward a long press
// M_DONE   | long press reported, waiting for release
// A_IDLE   | add/sub released, waiting for a fresh press
// A_HOLD   | one step issued, timing toward auto-repeat
// A_REPEAT | auto-repeat active, stepping every REPEAT_COUNT cycles
// A_LOCK   | add+sub chord seen, silent until both released
module button_event_gen #(
    parameter int unsigned LONG_COUNT   = 100_000_000,
    parameter int unsigned REPEAT_COUNT = 20_000_000
) (
    input  logic              clock,
    input  logic              reset,
    button_event_gen_if.slave bus
);
    localparam int unsigned MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
    localparam int          CNT_W     = $clog2(MAX_COUNT);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
    localparam logic DIR_ADD = 1'b0;
    localparam logic DIR_SUB = 1'b1;

    typedef enum logic [1:0] {M_IDLE, M_HELD, M_DONE} mode_state_t;
    typedef enum logic [1:0] {A_IDLE, A_HOLD, A_REPEAT, A_LOCK} adj_state_t;

    mode_state_t      mode_state;
    adj_state_t       adj_state;
    logic [CNT_W-1:0] mode_cnt;
    logic [CNT_W-1:0] adj_cnt;
    logic             mode_prev;
    logic             add_prev;
    logic             sub_prev;
    logic             dir;

    logic             mode_rise;
    logic             add_rise;
    logic             sub_rise;
    logic             dir_level;
    logic             other_level;
    logic [CNT_W-1:0] adj_last;

    assign mode_rise   = bus.mode_level & ~mode_prev;
    assign add_rise    = bus.add_level & ~add_prev;
    assign sub_rise    = bus.sub_level & ~sub_prev;
    assign dir_level   = (dir == DIR_SUB) ? bus.sub_level : bus.add_level;
    assign other_level = (dir == DIR_SUB) ? bus.add_level : bus.sub_level;
    assign adj_last    = (adj_state == A_HOLD) ? LONG_LAST : REPEAT_LAST;

    // prev resets high so a button held through reset needs a re-press
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_prev <= 1'b1;
            add_prev  <= 1'b1;
            sub_prev  <= 1'b1;
        end else begin
            mode_prev <= bus.mode_level;
            add_prev  <= bus.add_level;
            sub_prev  <= bus.sub_level;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_state     <= M_IDLE;
            mode_cnt       <= '0;
            bus.mode_short <= 1'b0;
            bus.mode_long  <= 1'b0;
        end else begin
            bus.mode_short <= 1'b0;
            bus.mode_long  <= 1'b0;
            case (mode_state)
                M_IDLE: begin
                    if (mode_rise) begin
                        mode_state <= M_HELD;
                        mode_cnt   <= '0;
                    end
                end
                M_HELD: begin
                    if (!bus.mode_level) begin
                        bus.mode_short <= 1'b1;
                        mode_state     <= M_IDLE;
                        mode_cnt       <= '0;
                    end else if (mode_cnt == LONG_LAST) begin
                        bus.mode_long <= 1'b1;
                        mode_state    <= M_DONE;
                        mode_cnt      <= '0;
                    end else begin
                        mode_cnt <= mode_cnt + 1'b1;
                    end
                end
                M_DONE: begin
                    if (!bus.mode_level) mode_state <= M_IDLE;
                end
                default: begin
                    mode_state <= M_IDLE;
                    mode_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adj_state     <= A_IDLE;
            adj_cnt       <= '0;
            dir           <= DIR_ADD;
            bus.add_step  <= 1'b0;
            bus.sub_step  <= 1'b0;
            bus.repeating <= 1'b0;
        end else begin
            bus.add_step <= 1'b0;
            bus.sub_step <= 1'b0;
            case (adj_state)
                A_IDLE: begin
                    // a chord is recognised even when only one of the two is new
                    if (bus.add_level && bus.sub_level && (add_rise || sub_rise)) begin
                        adj_state <= A_LOCK;
                    end else if (add_rise) begin
                        bus.add_step <= 1'b1;
                        dir          <= DIR_ADD;
                        adj_cnt      <= '0;
                        adj_state    <= A_HOLD;
                    end else if (sub_rise) begin
                        bus.sub_step <= 1'b1;
                        dir          <= DIR_SUB;
                        adj_cnt      <= '0;
                        adj_state    <= A_HOLD;
                    end
                end
                A_HOLD, A_REPEAT: begin
                    if (!dir_level) begin
                        adj_state     <= A_IDLE;
                        adj_cnt       <= '0;
                        bus.repeating <= 1'b0;
                    end else if (other_level) begin
                        adj_state     <= A_LOCK;
                        adj_cnt       <= '0;
                        bus.repeating <= 1'b0;
                    end else if (adj_cnt == adj_last) begin
                        bus.add_step  <= (dir == DIR_ADD);
                        bus.sub_step  <= (dir == DIR_SUB);
                        adj_cnt       <= '0;
                        adj_state     <= A_REPEAT;
                        bus.repeating <= 1'b1;
                    end else begin
                        adj_cnt <= adj_cnt + 1'b1;
                    end
                end
                A_LOCK: begin
                    if (!bus.add_level && !bus.sub_level) adj_state <= A_IDLE;
                end
                default: begin
                    adj_state     <= A_IDLE;
                    adj_cnt       <= '0;
                    bus.repeating <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: stimulus pushes cycle-stamped expected
// events, a negedge monitor pops and compares every observed pulse/edge.
module tb_button_event_gen;
    localparam int LONG = 8;
    localparam int REP  = 3;
    localparam int K_MS  = 0;
    localparam int K_ML  = 1;
    localparam int K_ADD = 2;
    localparam int K_SUB = 3;
    localparam int K_RUP = 4;
    localparam int K_RDN = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;

    button_event_gen_if bus();

    button_event_gen #(.LONG_COUNT(LONG), .REPEAT_COUNT(REP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n++;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic rep_prev = 1'b0;

    function automatic string kname(int k);
        case (k)
            K_MS:    return "mode_short";
            K_ML:    return "mode_long";
            K_ADD:   return "add_step";
            K_SUB:   return "sub_step";
            K_RUP:   return "repeating_rise";
            default: return "repeating_fall";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int cyc);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: seen at cycle %0d, none required", kname(kind), edge_n);
        end else begin
            if (exp_q[idx].cyc != edge_n) begin
                errors++;
                $display("FAIL %s: seen at cycle %0d, required at cycle %0d",
                         kname(kind), edge_n, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".mode_short"}, bus.mode_short, 1'b0);
        chk({tag, ".mode_long"},  bus.mode_long,  1'b0);
        chk({tag, ".add_step"},   bus.add_step,   1'b0);
        chk({tag, ".sub_step"},   bus.sub_step,   1'b0);
        chk({tag, ".repeating"},  bus.repeating,  1'b0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.mode_short) observe(K_MS);
            if (bus.mode_long)  observe(K_ML);
            if (bus.add_step)   observe(K_ADD);
            if (bus.sub_step)   observe(K_SUB);
            if (bus.repeating && !rep_prev) observe(K_RUP);
            if (!bus.repeating && rep_prev) observe(K_RDN);
            rep_prev = bus.repeating;
            checks++;
            if (bus.add_step && bus.sub_step) begin
                errors++;
                $display("FAIL step_exclusive: add_step=1 sub_step=1 at cycle %0d, required not both", edge_n);
            end
        end
    end

    // levels set here are sampled at edge edge_n+1
    task automatic drive(input logic m, input logic a, input logic s);
        @(negedge clock);
        bus.mode_level = m;
        bus.add_level  = a;
        bus.sub_level  = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        bus.mode_level = 1'b0;
        bus.add_level  = 1'b1;
        bus.sub_level  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk_outputs_zero("reset");
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;

        // add held through reset release: silent until re-pressed
        repeat (6) drive(1'b0, 1'b1, 1'b0);
        idle(3);

        // add held 3 cycles
        drive(1'b0, 1'b1, 1'b0);
        k = edge_n + 1;
        expect_ev(K_ADD, k);
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        idle(5);

        // sub held 20 cycles: step, long, then repeat cadence
        drive(1'b0, 1'b0, 1'b1);
        k = edge_n + 1;
        expect_ev(K_SUB, k);
        expect_ev(K_SUB, k + LONG);
        expect_ev(K_SUB, k + LONG + REP);
        expect_ev(K_SUB, k + LONG + 2 * REP);
        expect_ev(K_SUB, k + LONG + 3 * REP);
        expect_ev(K_RUP, k + LONG);
        expect_ev(K_RDN, k + 20);
        repeat (19) drive(1'b0, 1'b0, 1'b1);
        idle(5);

        // mode short (5 cycles)
        drive(1'b1, 1'b0, 1'b0);
        k = edge_n + 1;
        expect_ev(K_MS, k + 5);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        idle(4);

        // mode long (12 cycles), silent release
        drive(1'b1, 1'b0, 1'b0);
        k = edge_n + 1;
        expect_ev(K_ML, k + LONG);
        repeat (11) drive(1'b1, 1'b0, 1'b0);
        idle(4);

        // add held, sub joins at P+4: lockout until both released
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, i < 15, (i >= 4) && (i < 17));
            if (i == 0) begin
                k = edge_n + 1;
                expect_ev(K_ADD, k);
            end
        end
        idle(3);

        // add and sub rise together: no pulses
        for (int i = 0; i < 15; i++) drive(1'b0, i < 12, i < 12);
        idle(3);

        // reset mid-hold drops everything; re-press required
        drive(1'b0, 1'b1, 1'b0);
        k = edge_n + 1;
        expect_ev(K_ADD, k);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) drive(1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0);
        k = edge_n + 1;
        expect_ev(K_ADD, k);
        drive(1'b0, 1'b1, 1'b0);
        idle(3);

        // mode long during add auto-repeat; cadences independent
        for (int i = 0; i < 30; i++) begin
            drive((i >= 9) && (i < 19), i < 24, 1'b0);
            if (i == 0) begin
                k = edge_n + 1;
                expect_ev(K_ADD, k);
                for (int j = 0; j < 6; j++) expect_ev(K_ADD, k + LONG + j * REP);
                expect_ev(K_RUP, k + LONG);
                expect_ev(K_RDN, k + 24);
                expect_ev(K_ML, k + 9 + LONG);
            end
        end
        idle(5);

        mon_en = 1'b0;
        foreach (exp_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never seen, required at cycle %0d", kname(exp_q[i].kind), exp_q[i].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts the three debounced button levels (mode, add, sub) into single-cycle command events for the watch control FSM. Sits between the debounce instances and the watch interface. Distinguishes short from long mode presses, auto-repeats add/sub while held, and locks out add+sub chords. All outputs are registered single-cycle pulses or levels in the `clock` domain.

## Interface
- `LONG_COUNT`, default 100_000_000: hold time before a long-press or auto-repeat starts, in clock cycles (1 s at 100 MHz). Must be ≥ 2.
- `REPEAT_COUNT`, default 20_000_000: auto-repeat period in clock cycles (200 ms). Must be ≥ 1.
- `clock` input 1: 100 MHz system clock; the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `mode_level` input 1: debounced mode button level; 1 = pressed.
- `add_level` input 1: debounced add button level.
- `sub_level` input 1: debounced sub button level.
- `mode_short` output 1: one-cycle pulse when mode is released before a long press.
- `mode_long` output 1: one-cycle pulse when mode has been held for `LONG_COUNT`.
- `add_step` output 1: one-cycle increment pulse.
- `sub_step` output 1: one-cycle decrement pulse.
- `repeating` output 1: level, high while add/sub auto-repeat is active.

## Operation
- Each level is compared against a registered previous sample. A rise is `level & ~prev`.
- After reset, `prev` = 1 for all buttons. A button held through reset produces no event until it is released and pressed again.
- Mode FSM:
  - M_IDLE: on a mode rise, go to M_HELD and set cnt = 0.
  - M_HELD: checked in this order:
    - if `mode_level` = 0: pulse `mode_short`, go to M_IDLE;
    - else if cnt = `LONG_COUNT`−1: pulse `mode_long`, go to M_DONE;
    - else cnt++.
  - M_DONE: when `mode_level` = 0, go to M_IDLE. No pulse is generated on this release.
- Adjust FSM (shared by add and sub; the `dir` register selects add or sub):
  - A_IDLE:
    - add and sub both high with at least one rising: go to A_LOCK, no pulse. This includes both rising in the same cycle.
    - add rise alone: pulse `add_step`, dir = add, cnt = 0, go to A_HOLD.
    - sub rise alone: the same, with `sub_step` and dir = sub.
  - A_HOLD: checked in this order:
    - the dir button is low: go to A_IDLE;
    - the other button is high: go to A_LOCK;
    - cnt = `LONG_COUNT`−1: pulse the dir step, cnt = 0, go to A_REPEAT;
    - otherwise cnt++.
  - A_REPEAT: the same release and other-button rules as A_HOLD. When cnt = `REPEAT_COUNT`−1, pulse the dir step and set cnt = 0; otherwise cnt++.
  - A_LOCK: no pulses. Go to A_IDLE when both add and sub are low.
  - `repeating` = 1 exactly while in A_REPEAT.
- The mode FSM and the adjust FSM are independent. Mode events are generated normally while add/sub are held, and vice versa.
- Counters are unsigned with width $clog2 of the largest count. They never wrap, because they are cleared on every transition.
- `add_step` and `sub_step` are never high in the same cycle.

## Timing
- Reset (asynchronous, `reset` = 0):
  - all outputs 0;
  - both FSMs in their IDLE state;
  - counters 0;
  - `prev` = 1;
  - `dir` = add.
- Latency: a rise sampled at edge k produces its pulse in the cycle after edge k; call that cycle P.
- Add/sub held continuously: pulses at P, P+`LONG_COUNT`, then every `REPEAT_COUNT` cycles after that.
- `repeating` rises in cycle P+`LONG_COUNT` and falls one cycle after the release is sampled.
- Mode: `mode_long` at P'+`LONG_COUNT`, where P' is the cycle after the rise is sampled. `mode_short` is pulsed the cycle after the release is sampled, only if that release is sampled before `mode_long` fires.
- If `reset` is asserted mid-hold, all pending events are dropped. A button still held when reset releases is ignored until it is re-pressed.
- Every pulse is exactly one cycle wide.

## Test plan
All scenarios use `LONG_COUNT`=8 and `REPEAT_COUNT`=3.
- Add held for 3 cycles, then released -> exactly one `add_step`, 1 cycle after the rise; `repeating` stays 0.
- Sub held for 20 cycles -> `sub_step` pulses at P, P+8, P+11, P+14, P+17; `repeating` is high from P+8 until 1 cycle after release; no `add_step`.
- Mode held for 5 cycles -> one `mode_short` after release, no `mode_long`. Mode held for 12 cycles -> one `mode_long` at P'+8 and no `mode_short` on release.
- Add held, then sub raised at P+4 -> no further steps until both are released. Add and sub raised in the same cycle -> zero pulses.
- Add held across deassertion of `reset` -> no pulse. A later release and re-press -> `add_step` 1 cycle after the new rise.
- Mode pressed for 10 cycles during an add auto-repeat -> `mode_long` at P'+8 while the add repeat cadence is unchanged.
